wb_writer: RTL

//   Write-back stage driving the register file write port. Accepts retired results from MEM

---
 rtl/wb_writer_pkg.sv | 41 ++++
 rtl/wb_fifo2.sv | 52 +++++
 rtl/wb_writer.sv | 88 ++++++++
 3 files changed

// File: rtl/wb_writer_pkg.sv
// wb_writer_pkg.sv - shared widths, stall codes, FIFO entry layout and freeze helpers for the write-back stage
package wb_writer_pkg;

    localparam int REG_ADDR_LEN = 5;
    localparam int REG_LEN      = 32;
    localparam int STALL_LEN    = 2;
    localparam int CNT_LEN      = 32;

    // {we, addr, data} as one flat word so the FIFO stays a plain register array
    localparam int ENTRY_W      = 1 + REG_ADDR_LEN + REG_LEN;

    typedef enum logic [STALL_LEN-1:0] {
        NO_STALL       = 2'd0,
        STALL_NEXT_ONE = 2'd1,
        STALL_NEXT_TWO = 2'd2
    } stall_code_e;

    typedef struct packed {
        logic                    we;
        logic [REG_ADDR_LEN-1:0] addr;
        logic [REG_LEN-1:0]      data;
    } wb_entry_t;

    // Number of frozen cycles a stall request asks for; the unused code 3 asks for none.
    function automatic logic [1:0] stall_depth(input logic [STALL_LEN-1:0] code);
        case (code)
            STALL_NEXT_TWO: stall_depth = 2'd2;
            STALL_NEXT_ONE: stall_depth = 2'd1;
            default:        stall_depth = 2'd0;
        endcase
    endfunction

    function automatic logic [STALL_LEN-1:0] depth_to_code(input logic [1:0] depth);
        case (depth)
            2'd2:    depth_to_code = STALL_NEXT_TWO;
            2'd1:    depth_to_code = STALL_NEXT_ONE;
            default: depth_to_code = NO_STALL;
        endcase
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// wb_fifo2.sv - 2-entry in-order FIFO of write-back results
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_push, i_din     write one entry (caller guarantees not full)
//   i_pop             remove head (caller guarantees not empty)
//   o_head            oldest entry, valid while o_empty = 0
//   o_full, o_empty   occupancy flags from registered state
module wb_fifo2
    import wb_writer_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [ENTRY_W-1:0] i_din,
    output logic [ENTRY_W-1:0] o_head,
    output logic               o_full,
    output logic               o_empty
);

    logic [ENTRY_W-1:0] r_mem [2];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/wb_writer.sv
// wb_writer.sv - write-back stage: buffers MEM results, honours freeze requests, drives the register file write port
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_mem_valid / o_mem_ready        MEM handshake, transfer = valid & ready
//   i_mem_rd_we/addr/data            retired result fields
//   i_stall_req                      freeze request from hazard control
//   o_write_enable/addr/data         register file write port
//   o_stall_flag                     freeze code to the register file
//   o_retire_cnt                     entries popped since reset
//   o_busy                           FIFO non-empty or freeze active
module wb_writer
    import wb_writer_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_mem_valid,
    output logic                    o_mem_ready,
    input  logic                    i_mem_rd_we,
    input  logic [REG_ADDR_LEN-1:0] i_mem_rd_addr,
    input  logic [REG_LEN-1:0]      i_mem_rd_data,
    input  logic [STALL_LEN-1:0]    i_stall_req,
    output logic                    o_write_enable,
    output logic [REG_ADDR_LEN-1:0] o_write_addr,
    output logic [REG_LEN-1:0]      o_write_data,
    output logic [STALL_LEN-1:0]    o_stall_flag,
    output logic [CNT_LEN-1:0]      o_retire_cnt,
    output logic                    o_busy
);

    logic [1:0]         r_frz;
    logic [CNT_LEN-1:0] r_retire_cnt;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head_raw;
    wb_entry_t          w_head;
    wb_entry_t          w_din;
    logic [1:0]         w_req_depth;
    logic [1:0]         w_frz_dec;

    assign w_din = '{we: i_mem_rd_we, addr: i_mem_rd_addr, data: i_mem_rd_data};

    wb_fifo2 u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_head  (w_head_raw),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head = wb_entry_t'(w_head_raw);

    // Ready comes from registered occupancy only, so a pop never opens a slot in the same cycle.
    assign o_mem_ready = ~w_full;
    assign w_push      = i_mem_valid & ~w_full;

    assign w_req_depth = stall_depth(i_stall_req);
    assign w_frz_dec   = (r_frz != 2'd0) ? (r_frz - 2'd1) : 2'd0;

    // A fresh request freezes the head immediately, even before it reaches r_frz.
    assign w_pop = ~w_empty & (r_frz == 2'd0) & (w_req_depth == 2'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frz        <= 2'd0;
            r_retire_cnt <= '0;
        end else begin
            // A request only extends the freeze; a shorter one is absorbed by the running countdown.
            r_frz <= (w_req_depth > w_frz_dec) ? w_req_depth : w_frz_dec;
            if (w_pop) begin
                r_retire_cnt <= r_retire_cnt + 1'b1;
            end
        end
    end

    // x0 is hard-wired zero, so its entries retire without a register write.
    assign o_write_enable = w_pop & w_head.we & (w_head.addr != '0);
    assign o_write_addr   = w_empty ? '0 : w_head.addr;
    assign o_write_data   = w_empty ? '0 : w_head.data;
    assign o_stall_flag   = depth_to_code(r_frz);
    assign o_retire_cnt   = r_retire_cnt;
    assign o_busy         = ~w_empty | (r_frz != 2'd0);

endmodule
